// File: rtl/jam_perm_gen.sv
// Lexicographic permutation generator that feeds the JAM cost evaluator.
// Uses the classic next-permutation walk: find the pivot, swap it, then reverse the suffix one pair per cycle.
module jam_perm_gen #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CNTW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                perm_valid,
  input  logic                perm_ready,
  output logic [N*IDXW-1:0]   perm_data,
  output logic [CNTW-1:0]     perm_index,
  output logic                perm_last,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {S_IDLE, S_OUT, S_PIVOT, S_REV, S_DONE} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] a [N];
  logic [IDXW-1:0] lo, hi;
  logic [IDXW-1:0] piv_i, piv_j;
  logic            xfer;

  function automatic logic is_desc(input logic [N*IDXW-1:0] v);
    logic res;
    res = 1'b1;
    for (int w = 0; w < N-1; w++)
      if (v[w*IDXW +: IDXW] <= v[(w+1)*IDXW +: IDXW]) res = 1'b0;
    return res;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign perm_data[g*IDXW +: IDXW] = a[g];
  end

  assign xfer = perm_valid & perm_ready;

  // Later matches overwrite earlier ones, so both searches yield the largest index.
  always_comb begin
    piv_i = '0;
    piv_j = '0;
    for (int w = 0; w < N-1; w++)
      if (a[w] < a[w+1]) piv_i = IDXW'(w);
    for (int w = 1; w < N; w++)
      if ((IDXW'(w) > piv_i) && (a[w] > a[piv_i])) piv_j = IDXW'(w);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_OUT;
      S_OUT:   if (xfer) state_nx = perm_last ? S_DONE : S_PIVOT;
      S_PIVOT: state_nx = S_REV;
      S_REV:   if (!(lo < hi)) state_nx = S_OUT;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      perm_valid <= 1'b0;
      perm_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      perm_index <= '0;
      lo         <= '0;
      hi         <= '0;
      for (int w = 0; w < N; w++) a[w] <= IDXW'(w);
    end else begin
      state      <= state_nx;
      perm_valid <= (state_nx == S_OUT);
      busy       <= (state_nx == S_OUT) || (state_nx == S_PIVOT) || (state_nx == S_REV);
      done       <= (state_nx == S_DONE);
      // The suffix is final when REV exits, so the descending test sees the outgoing permutation.
      if ((state == S_REV) && (state_nx == S_OUT))
        perm_last <= is_desc(perm_data);
      else if (state_nx != S_OUT)
        perm_last <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int w = 0; w < N; w++) a[w] <= IDXW'(w);
            perm_index <= '0;
          end
        end
        S_OUT: begin
          if (xfer && !perm_last) perm_index <= perm_index + CNTW'(1);
        end
        S_PIVOT: begin
          a[piv_i] <= a[piv_j];
          a[piv_j] <= a[piv_i];
          lo       <= piv_i + IDXW'(1);
          hi       <= IDXW'(N-1);
        end
        S_REV: begin
          if (lo < hi) begin
            a[lo] <= a[hi];
            a[hi] <= a[lo];
            lo    <= lo + IDXW'(1);
            hi    <= hi - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_perm_gen.sv
// Bench for jam_perm_gen: an N=8 and an N=3 instance checked against a factoradic-based reference ordering.
module tb_jam_perm_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST = 1'b1;
  logic        start8 = 1'b0, rdy8 = 1'b0, start3 = 1'b0, rdy3 = 1'b0;
  logic        v8, l8, b8, dn8, v3, l3, b3, dn3;
  logic [23:0] d8;
  logic [5:0]  d3;
  logic [15:0] i8, i3;

  typedef struct {
    logic [23:0] d;
    int          idx;
    logic        last;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  jam_perm_gen #(.N(8), .IDXW(3), .CNTW(16)) dut8 (
    .CLK(CLK), .RST(RST), .start(start8), .perm_valid(v8), .perm_ready(rdy8),
    .perm_data(d8), .perm_index(i8), .perm_last(l8), .busy(b8), .done(dn8)
  );

  jam_perm_gen #(.N(3), .IDXW(2), .CNTW(16)) dut3 (
    .CLK(CLK), .RST(RST), .start(start3), .perm_valid(v3), .perm_ready(rdy3),
    .perm_data(d3), .perm_index(i3), .perm_last(l3), .busy(b3), .done(dn3)
  );

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int m = 2; m <= n; m++) f = f * m;
    return f;
  endfunction

  // Permutation number idx of n elements, decoded from its factorial-base digits.
  function automatic logic [23:0] exp_perm(input int n, input int wb, input int idx);
    int          rem[8];
    int          r, d, f;
    logic [23:0] res;
    res = '0;
    r   = idx;
    for (int k = 0; k < 8; k++) rem[k] = k;
    for (int p = 0; p < n; p++) begin
      f = fact(n-1-p);
      d = r / f;
      r = r % f;
      res = res | (24'(rem[d]) << (p*wb));
      for (int m = d; m < 7; m++) rem[m] = rem[m+1];
    end
    return res;
  endfunction

  // Low-valid cycles before the successor of prev appears: floor((N-1-i)/2) + 2.
  function automatic int exp_gap(input logic [23:0] prev);
    int i;
    i = 0;
    for (int k = 0; k < 7; k++)
      if (((prev >> (k*3)) & 24'h7) < ((prev >> ((k+1)*3)) & 24'h7)) i = k;
    return (7 - i) / 2 + 2;
  endfunction

  task automatic push8(input int from, input int to);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.d = exp_perm(8, 3, k); e.idx = k; e.last = (k == fact(8)-1);
      q8.push_back(e);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if ({v8, b8, dn8, l8} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctrl8 got %b want 0000", {v8, b8, dn8, l8}); end
    n_cmp++; if (i8 !== 16'd0) begin n_bad++; $display("FAIL reset_index8 got %0d want 0", i8); end
    n_cmp++; if (d8 !== 24'hFAC688) begin n_bad++; $display("FAIL reset_data8 got %h want fac688", d8); end
    n_cmp++; if ({v3, b3, dn3, l3} !== 4'b0000 || d3 !== 6'h24 || i3 !== 16'd0) begin
      n_bad++; $display("FAIL reset_n3 got ctrl=%b data=%h idx=%0d want 0000/24/0", {v3, b3, dn3, l3}, d3, i3);
    end
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  task automatic test_first_three;
    exp_t        e;
    logic [23:0] prev;
    int          got, gap, cyc;
    push8(0, 2);
    rdy8 = 1'b1;
    @(posedge CLK); #1 start8 = 1'b1;
    @(posedge CLK); #1 start8 = 1'b0;
    got = 0; gap = 0; cyc = 0; prev = '0;
    while (got < 3 && cyc < 50) begin
      @(negedge CLK); cyc++;
      if (v8 && rdy8) begin
        e = q8.pop_front();
        if (got == 0) begin
          n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL valid_latency got %0d want 1", cyc); end
          n_cmp++; if (b8 !== 1'b1) begin n_bad++; $display("FAIL busy_run got %b want 1", b8); end
        end else begin
          n_cmp++; if (gap != exp_gap(prev)) begin n_bad++; $display("FAIL gap_first idx=%0d got %0d want %0d", e.idx, gap, exp_gap(prev)); end
        end
        n_cmp++; if (d8 !== e.d || i8 !== 16'(e.idx) || l8 !== e.last) begin
          n_bad++; $display("FAIL first_xfer got %h/%0d/%b want %h/%0d/%b", d8, i8, l8, e.d, e.idx, e.last);
        end
        prev = e.d; got++; gap = 0;
      end else if (!v8) gap++;
    end
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL first_timeout got %0d want 3", got); end
    @(posedge CLK); #1 rdy8 = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t        e;
    logic [23:0] hd;
    logic [15:0] hi_;
    logic        hl;
    int          cyc;
    cyc = 0;
    do begin @(negedge CLK); cyc++; end while (!v8 && cyc < 20);
    hd = d8; hi_ = i8; hl = l8;
    push8(3, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      n_cmp++; if (v8 !== 1'b1 || d8 !== hd || i8 !== hi_ || l8 !== hl) begin
        n_bad++; $display("FAIL hold_stable cyc=%0d got %b/%h/%0d/%b want 1/%h/%0d/%b", c, v8, d8, i8, l8, hd, hi_, hl);
      end
    end
    @(posedge CLK); #1 rdy8 = 1'b1;
    @(negedge CLK);
    e = q8.pop_front();
    n_cmp++; if (v8 !== 1'b1 || d8 !== e.d || i8 !== 16'(e.idx) || l8 !== e.last) begin
      n_bad++; $display("FAIL release_xfer got %b/%h/%0d want 1/%h/%0d", v8, d8, i8, e.d, e.idx);
    end
    @(posedge CLK); #1 rdy8 = 1'b0;
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int   cyc;
    push8(4, 4);
    cyc = 0;
    do begin @(negedge CLK); cyc++; end while (!v8 && cyc < 20);
    @(posedge CLK); #1 start8 = 1'b1;
    @(posedge CLK); #1 start8 = 1'b0;
    @(negedge CLK);
    e = q8.pop_front();
    n_cmp++; if (v8 !== 1'b1 || d8 !== e.d || i8 !== 16'(e.idx)) begin
      n_bad++; $display("FAIL start_in_out got %b/%h/%0d want 1/%h/%0d", v8, d8, i8, e.d, e.idx);
    end
    @(posedge CLK); #1 rdy8 = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1 start8 = 1'b1;
    @(posedge CLK); #1 start8 = 1'b0;
  endtask

  task automatic test_long_reverse;
    exp_t        e;
    logic [23:0] prev;
    int          got, gap, cyc;
    push8(5, 5040);
    got = 0; gap = 0; cyc = 0; prev = '0;
    while (got < 5036 && cyc < 30000) begin
      @(negedge CLK); cyc++;
      if (v8 && rdy8) begin
        e = q8.pop_front();
        n_cmp++; if (d8 !== e.d || i8 !== 16'(e.idx) || l8 !== e.last) begin
          n_bad++; $display("FAIL run_xfer got %h/%0d/%b want %h/%0d/%b", d8, i8, l8, e.d, e.idx, e.last);
        end
        if (got > 0) begin
          n_cmp++; if (gap != exp_gap(prev)) begin n_bad++; $display("FAIL run_gap idx=%0d got %0d want %0d", e.idx, gap, exp_gap(prev)); end
        end
        if (e.idx == 5040) begin
          n_cmp++; if (gap != 5) begin n_bad++; $display("FAIL longest_rev_gap got %0d want 5", gap); end
        end
        prev = e.d; got++; gap = 0;
      end else if (!v8) gap++;
    end
    n_cmp++; if (got != 5036) begin n_bad++; $display("FAIL run_timeout got %0d want 5036", got); end
  endtask

  task automatic test_rst_mid_rev;
    int cyc;
    @(posedge CLK); #1 rdy8 = 1'b0;
    @(posedge CLK); #2 RST = 1'b1;
    #1;
    n_cmp++; if ({v8, b8, dn8, l8} !== 4'b0000 || i8 !== 16'd0) begin
      n_bad++; $display("FAIL async_rst_ctrl got %b/%0d want 0000/0", {v8, b8, dn8, l8}, i8);
    end
    n_cmp++; if (d8 !== 24'hFAC688) begin n_bad++; $display("FAIL async_rst_data got %h want fac688", d8); end
    @(posedge CLK); #1 RST = 1'b0;
    rdy8 = 1'b1; start8 = 1'b1;
    @(posedge CLK); #1 start8 = 1'b0;
    cyc = 0;
    do begin @(negedge CLK); cyc++; end while (!v8 && cyc < 20);
    n_cmp++; if (v8 !== 1'b1 || d8 !== 24'hFAC688 || i8 !== 16'd0) begin
      n_bad++; $display("FAIL restart got %b/%h/%0d want 1/fac688/0", v8, d8, i8);
    end
    @(posedge CLK); #1 rdy8 = 1'b0;
  endtask

  task automatic test_full_n3;
    exp_t e;
    int   got, cyc, dcnt;
    for (int k = 0; k < 6; k++) begin
      e.d = exp_perm(3, 2, k); e.idx = k; e.last = (k == 5);
      q3.push_back(e);
    end
    rdy3 = 1'b1;
    @(posedge CLK); #1 start3 = 1'b1;
    @(posedge CLK); #1 start3 = 1'b0;
    got = 0; cyc = 0; dcnt = 0;
    while (got < 6 && cyc < 100) begin
      @(negedge CLK); cyc++;
      if (dn3) dcnt++;
      if (v3 && rdy3) begin
        e = q3.pop_front();
        n_cmp++; if (d3 !== e.d[5:0] || i3 !== 16'(e.idx) || l3 !== e.last) begin
          n_bad++; $display("FAIL n3_xfer got %h/%0d/%b want %h/%0d/%b", d3, i3, l3, e.d[5:0], e.idx, e.last);
        end
        got++;
      end
    end
    for (int c = 0; c < 6; c++) begin @(negedge CLK); if (dn3) dcnt++; end
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL n3_count got %0d want 6", got); end
    n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL n3_done_pulses got %0d want 1", dcnt); end
    n_cmp++; if (b3 !== 1'b0 || v3 !== 1'b0) begin n_bad++; $display("FAIL n3_idle got busy=%b valid=%b want 0/0", b3, v3); end
    rdy3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_three();
    test_backpressure();
    test_start_ignored();
    test_long_reverse();
    test_rst_mid_rev();
    test_full_n3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
